// File: rtl/tinyalu_pkg.sv
// Shared types, error bit indices and the reference result model for the TinyALU checker.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_POST
    } state_e;

    localparam int ERR_SPURIOUS = 0;
    localparam int ERR_LATE     = 1;
    localparam int ERR_EARLY    = 2;
    localparam int ERR_DATA     = 3;
    localparam int ERR_STABLE   = 4;
    localparam int ERR_PROTO    = 5;
    localparam int ERR_RESET    = 6;
    localparam int ERR_OP       = 7;
    localparam int ERR_W        = 8;

    // Widest operand the model supports; callers zero-extend into it and cast the result back down.
    localparam int MAX_DATA_W = 32;

    function automatic logic op_accepted(input logic [2:0] op);
        return op inside {OP_ADD, OP_AND, OP_XOR, OP_MUL};
    endfunction

    function automatic logic op_invalid(input logic [2:0] op);
        return !(op inside {OP_NOP, OP_ADD, OP_AND, OP_XOR, OP_MUL});
    endfunction

    function automatic logic [2*MAX_DATA_W-1:0] exp_result(
        input logic [2:0]            op,
        input logic [MAX_DATA_W-1:0] a,
        input logic [MAX_DATA_W-1:0] b
    );
        logic [2*MAX_DATA_W-1:0] ax;
        logic [2*MAX_DATA_W-1:0] bx;
        ax = {{MAX_DATA_W{1'b0}}, a};
        bx = {{MAX_DATA_W{1'b0}}, b};
        case (op)
            OP_ADD:  exp_result = ax + bx;
            OP_AND:  exp_result = ax & bx;
            OP_XOR:  exp_result = ax ^ bx;
            OP_MUL:  exp_result = ax * bx;
            default: exp_result = '0;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_sat_cnt.sv
// Saturating up-counter with a clear that yields to a same-cycle increment.
module tinyalu_sat_cnt
    import tinyalu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/tinyalu_checker.sv
// Passive TinyALU monitor: tracks one outstanding op, predicts result and done timing,
// and reports sticky error flags plus saturating error and completion counts.
module tinyalu_checker
    import tinyalu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MULT_LAT   = 4,
    parameter int CNT_W      = 16,
    parameter int CHK_STABLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [2:0]          op,
    input  logic                start,
    input  logic                done,
    input  logic [2*DATA_W-1:0] result,
    output logic                busy,
    output logic [7:0]          err_flags,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    add_cnt,
    output logic [CNT_W-1:0]    and_cnt,
    output logic [CNT_W-1:0]    xor_cnt,
    output logic [CNT_W-1:0]    mul_cnt
);

    localparam int LAT_W = $clog2(MULT_LAT + 1);

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic [2*DATA_W-1:0] exp_q, exp_d;
    logic                post_rst_q, post_rst_d;
    logic [ERR_W-1:0]    err_flags_q, err_flags_d;
    logic [ERR_W-1:0]    err_now;
    logic                done_ok;

    // The latency counter reads 1 in the cycle where done is due, for every op.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        exp_d      = exp_q;
        post_rst_d = 1'b0;
        err_now    = '0;
        done_ok    = 1'b0;

        if (post_rst_q && (done || (result != '0))) begin
            err_now[ERR_RESET] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    err_now[ERR_SPURIOUS] = 1'b1;
                end
                if (start && op_accepted(op)) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    exp_d   = (2*DATA_W)'(exp_result(op, MAX_DATA_W'(A), MAX_DATA_W'(B)));
                    lat_d   = (op == OP_MUL) ? LAT_W'(MULT_LAT) : LAT_W'(1);
                    state_d = ST_WAIT;
                end else if (start && op_invalid(op)) begin
                    err_now[ERR_OP] = 1'b1;
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    if (done) begin
                        if (result != exp_q) begin
                            err_now[ERR_DATA] = 1'b1;
                        end else begin
                            done_ok = 1'b1;
                        end
                        state_d = ST_POST;
                    end else begin
                        err_now[ERR_LATE] = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    if ((CHK_STABLE != 0) && (op_q == OP_MUL) &&
                        ((A != a_q) || (B != b_q) || (op != op_q))) begin
                        err_now[ERR_STABLE] = 1'b1;
                    end
                    if (done) begin
                        err_now[ERR_EARLY] = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_POST: begin
                if (start || done) begin
                    err_now[ERR_PROTO] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_flags_d = clr ? err_now : (err_flags_q | err_now);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            exp_q       <= '0;
            post_rst_q  <= 1'b1;
            err_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            exp_q       <= exp_d;
            post_rst_q  <= post_rst_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign busy      = (state_q == ST_WAIT);
    assign err_flags = err_flags_q;

    tinyalu_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(|err_now), .count_o(err_cnt)
    );

    tinyalu_sat_cnt #(.W(CNT_W)) u_add_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(done_ok && (op_q == OP_ADD)), .count_o(add_cnt)
    );

    tinyalu_sat_cnt #(.W(CNT_W)) u_and_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(done_ok && (op_q == OP_AND)), .count_o(and_cnt)
    );

    tinyalu_sat_cnt #(.W(CNT_W)) u_xor_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(done_ok && (op_q == OP_XOR)), .count_o(xor_cnt)
    );

    tinyalu_sat_cnt #(.W(CNT_W)) u_mul_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(done_ok && (op_q == OP_MUL)), .count_o(mul_cnt)
    );

endmodule
